// File: rtl/riscv_types.sv
`default_nettype none
// ============================================================================
// Module   : riscv_types (package)
// Purpose  : Shared types for the RV32I load/store path.
//            mem_op_t    - fun3 encodings of loads and stores
//            lsu_state_t - bus bridge sequencing states
// Revision : 1.0 - initial release
// ============================================================================
package riscv_types;

    // Loads use all five codes; stores use OP_B/OP_H/OP_W only.
    typedef enum logic [2:0] {
        OP_B  = 3'b000,
        OP_H  = 3'b001,
        OP_W  = 3'b010,
        OP_BU = 3'b100,
        OP_HU = 3'b101
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [3:0] c_SEL_BYTE = 4'b0001;
    localparam logic [3:0] c_SEL_HALF = 4'b0011;
    localparam logic [3:0] c_SEL_WORD = 4'b1111;

endpackage : riscv_types
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Purpose  : Combinational lane steering for the load/store bridge.
//            Store side: byte selects, replicated store data, legality check.
//            Load side : lane extraction and sign/zero extension.
// Ports    : off/op/is_store/access/wdata -> sel/st_data/bad  (MEM access)
//            ld_off/ld_op/rdata           -> ld_data         (bus return)
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import riscv_types::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  op,
    input  logic        is_store,
    input  logic        access,
    input  logic [31:0] wdata,
    output logic [3:0]  sel,
    output logic [31:0] st_data,
    output logic        bad,
    input  logic [1:0]  ld_off,
    input  logic [2:0]  ld_op,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic        w_bad;
    logic [31:0] w_lane;

    always_comb begin
        sel     = 4'b0000;
        st_data = 32'd0;
        w_bad   = 1'b0;
        case (op)
            OP_B: begin
                sel     = c_SEL_BYTE << off;
                st_data = {4{wdata[7:0]}};
            end
            OP_H: begin
                sel     = c_SEL_HALF << off;
                st_data = {2{wdata[15:0]}};
                w_bad   = off[0];
            end
            OP_W: begin
                sel     = c_SEL_WORD;
                st_data = wdata;
                w_bad   = (off != 2'b00);
            end
            // Unsigned variants exist only for loads.
            OP_BU: begin
                sel   = c_SEL_BYTE << off;
                w_bad = is_store;
            end
            OP_HU: begin
                sel   = c_SEL_HALF << off;
                w_bad = off[0] | is_store;
            end
            default: w_bad = 1'b1;
        endcase
    end

    assign bad = access & w_bad;

    // Shift the addressed lane down to bit 0 before extending.
    assign w_lane = rdata >> {ld_off, 3'b000};

    always_comb begin
        ld_data = 32'd0;
        case (ld_op)
            OP_B:    ld_data = {{24{w_lane[7]}}, w_lane[7:0]};
            OP_H:    ld_data = {{16{w_lane[15]}}, w_lane[15:0]};
            OP_W:    ld_data = w_lane;
            OP_BU:   ld_data = {24'd0, w_lane[7:0]};
            OP_HU:   ld_data = {16'd0, w_lane[15:0]};
            default: ld_data = 32'd0;
        endcase
    end

endmodule : lsu_align
`default_nettype wire

// File: rtl/lsu_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : lsu_bus_bridge
// Purpose  : MEM-stage load/store to Wishbone-classic bridge. One bus cycle
//            per access; stalls the pipeline while outstanding; returns
//            extended load data held for the WB stage.
// Ports    : clk, reset (async, active-high)
//            mem_*_mem      - MEM-stage access (address, data, fun3, kind)
//            mem_rdata_wb   - registered load result
//            lsu_stall      - pipeline hold request
//            misalign_err   - pulse on illegal/misaligned access
//            bus_err        - pulse on err_i termination
//            cyc_o..dat_i   - Wishbone master
// Revision : 1.0 - initial release
// ============================================================================
module lsu_bus_bridge
    import riscv_types::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       mem_addr_mem,
    input  logic [31:0]       mem_wdata_mem,
    input  logic [2:0]        mem_op_mem,
    input  logic              mem_write_mem,
    input  logic              mem_to_reg_mem,
    output logic [31:0]       mem_rdata_wb,
    output logic              lsu_stall,
    output logic              misalign_err,
    output logic              bus_err,
    output logic              cyc_o,
    output logic              stb_o,
    output logic              we_o,
    output logic [ADDR_W-3:0] adr_o,
    output logic [3:0]        sel_o,
    output logic [31:0]       dat_o,
    input  logic [31:0]       dat_i,
    input  logic              ack_i,
    input  logic              err_i
);

    lsu_state_t        r_state;
    logic              r_cyc;
    logic              r_we;
    logic [ADDR_W-3:0] r_adr;
    logic [3:0]        r_sel;
    logic [31:0]       r_dat;
    logic [31:0]       r_rdata;
    logic              r_bus_err;
    logic [2:0]        r_op;
    logic [1:0]        r_off;
    logic              r_is_load;

    logic              w_access;
    logic              w_bad;
    logic              w_legal;
    logic [3:0]        w_sel;
    logic [31:0]       w_st_data;
    logic [31:0]       w_ld_data;

    // A store wins when both write and load flags are set.
    assign w_access = mem_write_mem | mem_to_reg_mem;
    assign w_legal  = w_access & ~w_bad;

    lsu_align u_align (
        .off      (mem_addr_mem[1:0]),
        .op       (mem_op_mem),
        .is_store (mem_write_mem),
        .access   (w_access),
        .wdata    (mem_wdata_mem),
        .sel      (w_sel),
        .st_data  (w_st_data),
        .bad      (w_bad),
        .ld_off   (r_off),
        .ld_op    (r_op),
        .rdata    (dat_i),
        .ld_data  (w_ld_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_sel     <= 4'b0000;
            r_dat     <= 32'd0;
            r_rdata   <= 32'd0;
            r_bus_err <= 1'b0;
            r_op      <= 3'b000;
            r_off     <= 2'b00;
            r_is_load <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_legal) begin
                        r_cyc     <= 1'b1;
                        r_we      <= mem_write_mem;
                        r_adr     <= mem_addr_mem[ADDR_W-1:2];
                        r_sel     <= w_sel;
                        r_dat     <= w_st_data;
                        r_op      <= mem_op_mem;
                        r_off     <= mem_addr_mem[1:0];
                        r_is_load <= ~mem_write_mem;
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    // ack has priority over a simultaneous err.
                    if (ack_i) begin
                        r_cyc   <= 1'b0;
                        r_state <= DONE;
                        if (r_is_load) begin
                            r_rdata <= w_ld_data;
                        end
                    end else if (err_i) begin
                        r_cyc     <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_state   <= DONE;
                        if (r_is_load) begin
                            r_rdata <= 32'd0;
                        end
                    end
                end
                // Pipeline advances this cycle; the next MEM instruction is
                // only looked at once we are back in IDLE.
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign lsu_stall    = ((r_state == IDLE) & w_legal) | (r_state == BUSY);
    assign misalign_err = (r_state == IDLE) & w_bad;

    assign cyc_o        = r_cyc;
    assign stb_o        = r_cyc;
    assign we_o         = r_we;
    assign adr_o        = r_adr;
    assign sel_o        = r_sel;
    assign dat_o        = r_dat;
    assign mem_rdata_wb = r_rdata;
    assign bus_err      = r_bus_err;

endmodule : lsu_bus_bridge
`default_nettype wire
